// File: rtl/serv_bus_bridge.sv
// serv_bus_bridge: arbitrates SERV ibus/dbus onto a single-port RAM or a peripheral Wishbone port
module serv_bus_bridge #(
    parameter  int MEM_BYTES = 8192,
    parameter  int TIMEOUT   = 255,
    localparam int AW        = $clog2(MEM_BYTES / 4),
    localparam int TW        = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic [31:0]   i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [31:0]   i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [AW-1:0] o_mem_adr,
    output logic          o_mem_en,
    output logic [3:0]    o_mem_we,
    output logic [31:0]   o_mem_wdat,
    input  logic [31:0]   i_mem_rdat,
    output logic [31:0]   o_per_adr,
    output logic [31:0]   o_per_dat,
    output logic [3:0]    o_per_sel,
    output logic          o_per_we,
    output logic          o_per_cyc,
    input  logic [31:0]   i_per_rdt,
    input  logic          i_per_ack,
    output logic          o_per_err
);
    typedef enum logic [2:0] {IDLE, MEM, PER, ACK, GAP} state_t;
    state_t state, state_nxt;
    logic dsel;
    logic [31:0] adr, dat, pdat, gadr, rdt;
    logic [3:0] sel;
    logic we, gnt, to, hit, ack, run;
    logic [TW-1:0] cnt;
    assign run  = !i_rst;
    assign gnt  = i_dbus_cyc | i_ibus_cyc;
    assign gadr = i_dbus_cyc ? i_dbus_adr : i_ibus_adr;
    assign hit  = adr < 32'(MEM_BYTES);
    assign to   = (cnt == TW'(TIMEOUT - 1)) && !i_per_ack;
    // State register, request latch, timeout counter and captured peripheral data
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            dsel  <= 1'b0;
            adr   <= '0;
            dat   <= '0;
            sel   <= '0;
            we    <= 1'b0;
            cnt   <= '0;
            pdat  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt <= '0;
                if (gnt) begin
                    dsel <= i_dbus_cyc;
                    adr  <= gadr;
                    dat  <= i_dbus_cyc ? i_dbus_dat : '0;
                    sel  <= i_dbus_cyc ? i_dbus_sel : 4'hf;
                    we   <= i_dbus_cyc & i_dbus_we;
                end
            end
            if (state == PER) begin
                if (i_per_ack) pdat <= i_per_rdt;
                else begin
                    cnt <= cnt + TW'(1);
                    if (to) pdat <= '0;
                end
            end
        end
    end
    // Next-state decode; dbus has priority, GAP keeps a stale cyc from being re-granted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt) state_nxt = (gadr < 32'(MEM_BYTES)) ? MEM : PER;
            MEM:     state_nxt = ACK;
            PER:     if (i_per_ack || to) state_nxt = ACK;
            ACK:     state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign o_mem_en   = run && state == MEM;
    assign o_mem_we   = (o_mem_en && we) ? sel : 4'h0;
    assign o_mem_adr  = adr[AW+1:2];
    assign o_mem_wdat = dat;
    assign o_per_cyc  = run && state == PER;
    assign o_per_err  = o_per_cyc && to;
    assign o_per_adr  = adr;
    assign o_per_dat  = dat;
    assign o_per_sel  = sel;
    assign o_per_we   = we;
    assign ack        = run && state == ACK;
    assign rdt        = (ack && !we) ? (hit ? i_mem_rdat : pdat) : 32'h0;
    assign o_dbus_ack = ack && dsel;
    assign o_ibus_ack = ack && !dsel;
    assign o_dbus_rdt = dsel ? rdt : 32'h0;
    assign o_ibus_rdt = dsel ? 32'h0 : rdt;
endmodule

// File: doc/serv_bus_bridge.md
Name: serv_bus_bridge

Overview:
- Consumes the instruction and data Wishbone buses of the SERV core wrapper (core plus register-file RAM).
- Arbitrates them onto one single-port synchronous on-chip RAM port, or a peripheral Wishbone port, selected by address decode.
- Generates single-cycle acks that satisfy SERV's bus rules.
- A timeout counter guarantees that a silent peripheral cannot hang the core.

Parameters:
- MEM_BYTES, 8192: RAM size in bytes, power of two, at least 8. Byte addresses below MEM_BYTES map to RAM.
- AW, $clog2(MEM_BYTES/4): RAM word-address width. Derived, do not override.
- TIMEOUT, 255: peripheral wait cycles before a forced ack. Range 1..65535.
- TW, $clog2(TIMEOUT+1): timeout counter width. Derived.

Ports:
- clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_ibus_adr  in  32  instruction byte address
- i_ibus_cyc  in  1  instruction request
- o_ibus_rdt  out  32  instruction read data
- o_ibus_ack  out  1  instruction ack
- i_dbus_adr  in  32  data byte address
- i_dbus_dat  in  32  data write data
- i_dbus_sel  in  4  data byte enables
- i_dbus_we  in  1  data write
- i_dbus_cyc  in  1  data request
- o_dbus_rdt  out  32  data read data
- o_dbus_ack  out  1  data ack
- o_mem_adr  out  AW  RAM word address
- o_mem_en  out  1  RAM access strobe
- o_mem_we  out  4  RAM byte write enables
- o_mem_wdat  out  32  RAM write data
- i_mem_rdat  in  32  RAM read data, valid the cycle after o_mem_en and held until the next access
- o_per_adr  out  32  peripheral address
- o_per_dat  out  32  peripheral write data
- o_per_sel  out  4  peripheral byte enables
- o_per_we  out  1  peripheral write
- o_per_cyc  out  1  peripheral request
- i_per_rdt  in  32  peripheral read data
- i_per_ack  in  1  peripheral ack
- o_per_err  out  1  one-cycle pulse on peripheral timeout

Behaviour:
- Reset: state IDLE; all acks, o_mem_en, o_mem_we, o_per_cyc and o_per_err are 0; counter is 0; latched request registers are 0. Reset asserted in any state aborts the transaction: no ack and no RAM write is issued afterwards.
- States: IDLE, MEM, PER, ACK, GAP.
- IDLE:
  - If i_dbus_cyc, grant dbus; else if i_ibus_cyc, grant ibus. dbus wins when both are asserted.
  - On grant, latch master, adr, dat, sel and we. ibus is always treated as a read with sel=4'hf.
  - Decode: adr < MEM_BYTES goes to MEM, otherwise to PER. Counter clears.
- MEM (1 cycle):
  - o_mem_en=1; o_mem_adr = latched adr[AW+1:2]; o_mem_wdat = latched dat.
  - o_mem_we = latched sel if we, else 0.
  - Next state ACK.
- PER:
  - o_per_cyc=1 with the latched adr/dat/sel/we held stable.
  - On i_per_ack: latch i_per_rdt and go to ACK.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and no ack: pulse o_per_err, latch read data 0, go to ACK.
  - If ack and timeout coincide, ack wins and o_per_err stays 0.
  - o_per_cyc deasserts the cycle after ack or timeout.
- ACK (1 cycle):
  - Ack of the granted master only is 1.
  - Its rdt is i_mem_rdat for a RAM target, or the latched peripheral data for a peripheral target. This applies to reads; writes return 0.
  - The non-granted master's rdt is 0. Both rdt outputs are 0 outside ACK.
- GAP (1 cycle):
  - No grant. This lets SERV drop cyc after the ack, so a stale cyc is never re-accepted.
  - Next state IDLE.
- Latency, cyc seen in IDLE at cycle 0:
  - RAM: ack at cycle 2, next grant possible at cycle 4.
  - Peripheral acking k cycles after o_per_cyc rises (k≥0, ack seen in cycle 1+k): ack at cycle 2+k.
  - Peripheral timeout: ack at cycle 1+TIMEOUT.
- i_per_ack outside PER is ignored.
- Master cyc deassertion mid-transaction, which is illegal, is ignored: the transaction completes and acks.
- Address bits [1:0] are ignored for RAM; the full 32-bit address is forwarded to the peripheral.
- A RAM address wraps only through truncation to AW bits; decode already excludes out-of-range addresses.

Test Plan:
- ibus cyc, adr 0x10, RAM holds 0x00000013 at word 4 → o_mem_en at cycle 1 with o_mem_adr=4, o_mem_we=0; o_ibus_ack at cycle 2 with rdt=0x00000013; no grant at cycle 3.
- dbus write, adr 0x104, dat 0xA5A5_1234, sel 4'b0011 → o_mem_we=4'b0011 and o_mem_adr=0x41 at cycle 1; o_dbus_ack at cycle 2 with rdt=0. A following read of 0x104 returns the bytes 0x34 and 0x12 in the low half.
- ibus and dbus asserted in the same cycle, both RAM → dbus acked at cycle 2; ibus granted at cycle 4 and acked at cycle 6; acks never overlap.
- dbus read of 0x4000_0000, peripheral acks 3 cycles after o_per_cyc with rdt 0xDEAD_BEEF → o_per_cyc high for cycles 1..4; o_dbus_ack at cycle 5 with rdt=0xDEAD_BEEF; o_per_err=0.
- Peripheral never acks, TIMEOUT=4 → o_per_err pulses at cycle 4; o_dbus_ack at cycle 5 with rdt=0. With the ack arriving exactly in cycle 4 instead, ack at cycle 5 with peripheral data and no err.
- i_rst asserted during PER → next cycle IDLE, o_per_cyc=0, no ack. The core's reissued request is served normally.
